// File: rtl/data_mem_subword_pkg.sv
// rtl/data_mem_subword_pkg.sv - shared load/store encodings for the sub-word data memory
// Purpose: access-size encodings and controller state encoding shared by the
//          load/store path (data_mem_subword, mem_lane_align).
// Ports:   none (package).
package data_mem_subword_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering and load extension for sub-word accesses
// Purpose: combinational lane logic shared by stores and loads.
// Ports:   size/is_signed/byte_off   - access descriptor (byte_off = addr[1:0])
//          store_data                - right-aligned store data
//          mem_word                  - current contents of the addressed word
//          store_lanes/store_be      - store data replicated onto lanes + byte enables
//          load_data                 - addressed lanes, zero/sign extended to 32 bits
module mem_lane_align
  import data_mem_subword_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [31:0] store_lanes,
  output logic [3:0]  store_be,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Bring the addressed lane(s) down to bit 0 before extension.
  assign shifted = mem_word >> {byte_off, 3'b000};

  always_comb begin
    store_lanes = store_data;
    store_be    = 4'b0000;
    load_data   = 32'h0;
    case (size)
      SIZE_B: begin
        // Replicating onto every lane lets the byte enable pick the target.
        store_lanes = {4{store_data[7:0]}};
        store_be    = 4'b0001 << byte_off;
        load_data   = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        store_lanes = {2{store_data[15:0]}};
        store_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        load_data   = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        store_lanes = store_data;
        store_be    = 4'b1111;
        load_data   = mem_word;
      end
      default: begin
        store_be  = 4'b0000;
        load_data = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_subword.sv
// rtl/data_mem_subword.sv - byte/half/word data memory with fixed-latency responses
// Purpose: single-port data memory with byte-enabled stores, sign/zero-extended
//          loads, alignment/range fault detection and an optional zero sweep
//          after reset.
// Ports:   clk, rst (async, active-high)
//          req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata - request
//          rsp_valid/rsp_rdata/rsp_err - response, READ_LATENCY cycles after accept
//          err_addr - address of the most recent faulting request
module data_mem_subword
  import data_mem_subword_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] err_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] widx;
  logic          accept;
  logic          fault;
  logic [31:0]   store_lanes;
  logic [3:0]    store_be;
  logic [31:0]   load_data;

  logic [READ_LATENCY-1:0] pipe_v;
  logic [READ_LATENCY-1:0] pipe_e;
  logic [31:0]             pipe_d [READ_LATENCY];

  assign widx      = req_addr[AW+1:2];
  assign req_ready = (state == ST_READY) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    // Any address bit above the word index means the word is out of range.
    fault = |req_addr[31:AW+2];
    case (req_size)
      SIZE_B: begin
      end
      SIZE_H: if (req_addr[0]) fault = 1'b1;
      SIZE_W: if (req_addr[1:0] != 2'b00) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  mem_lane_align u_align (
    .size        (req_size),
    .is_signed   (req_signed),
    .byte_off    (req_addr[1:0]),
    .store_data  (req_wdata),
    .mem_word    (mem[widx]),
    .store_lanes (store_lanes),
    .store_be    (store_be),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // Storage has no reset; it is defined only by the sweep or by stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_idx] <= 32'h0;
      end else if (accept && req_write && !fault) begin
        for (int b = 0; b < 4; b++) begin
          if (store_be[b]) mem[widx][8*b +: 8] <= store_lanes[8*b +: 8];
        end
      end
    end
  end

  // Load data is captured at acceptance (array read is combinational), so a
  // load right after a store already sees the committed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= 32'h0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && fault;
      pipe_d[0] <= (accept && !fault && !req_write) ? load_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err_addr <= 32'h0;
    else if (accept && fault) err_addr <= req_addr;
  end

  assign rsp_valid = pipe_v[READ_LATENCY-1];
  assign rsp_err   = pipe_e[READ_LATENCY-1];
  assign rsp_rdata = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_subword.sv
// tb/tb_data_mem_subword.sv - directed self-checking bench for data_mem_subword
module tb_data_mem_subword;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n;

  // Instance a: DEPTH=256, READ_LATENCY=1
  logic        rst, req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, err_addr;

  // Instance b: DEPTH=16, READ_LATENCY=2
  logic        rst_b, req_valid_b, req_write_b, req_signed_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b, err_addr_b;

  data_mem_subword #(.DEPTH(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_addr(err_addr)
  );

  data_mem_subword #(.DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_size(req_size_b), .req_signed(req_signed_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .err_addr(err_addr_b)
  );

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_a(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic rsp_a(input string tag, input logic e, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".err"},   32'(rsp_err),   32'(e));
    chk({tag, ".rdata"}, rsp_rdata,      d);
  endtask

  task automatic drive_b(input logic w, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] wd);
    req_valid_b = 1'b1; req_write_b = w; req_size_b = sz; req_signed_b = 1'b0;
    req_addr_b = ad; req_wdata_b = wd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = W; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst_b = 1'b1; req_valid_b = 1'b0; req_write_b = 1'b0; req_size_b = W;
    req_signed_b = 1'b0; req_addr_b = 32'h0; req_wdata_b = 32'h0;
    repeat (3) step();

    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err",   32'(rsp_err), 32'd0);
    chk("rst.err_addr",  err_addr, 32'h0);

    rst = 1'b0; rst_b = 1'b0;
    chk("clear.ready_lo", 32'(req_ready), 32'd0);
    n = 0;
    while (!req_ready && n < 2000) begin step(); n++; end
    chk("clear.len", 32'(n), 32'd256);
    chk("clear.ready_hi", 32'(req_ready), 32'd1);

    acc_a(1'b0, W, 1'b0, 32'h40, 32'h0);           rsp_a("lw40", 1'b0, 32'h0);
    step();
    chk("pulse.once", 32'(rsp_valid), 32'd0);

    acc_a(1'b1, W, 1'b0, 32'h10, 32'h11223344);    rsp_a("sw10", 1'b0, 32'h0);
    acc_a(1'b1, B, 1'b0, 32'h12, 32'h123456AA);    rsp_a("sb12", 1'b0, 32'h0);
    acc_a(1'b0, W, 1'b0, 32'h10, 32'h0);           rsp_a("lw10", 1'b0, 32'h11AA3344);

    acc_a(1'b1, W, 1'b0, 32'h20, 32'h000080F0);    rsp_a("sw20", 1'b0, 32'h0);
    acc_a(1'b0, H, 1'b1, 32'h20, 32'h0);           rsp_a("lh20", 1'b0, 32'hFFFF80F0);
    acc_a(1'b0, H, 1'b0, 32'h20, 32'h0);           rsp_a("lhu20", 1'b0, 32'h000080F0);
    acc_a(1'b0, B, 1'b1, 32'h21, 32'h0);           rsp_a("lb21", 1'b0, 32'hFFFFFF80);
    acc_a(1'b0, B, 1'b0, 32'h21, 32'h0);           rsp_a("lbu21", 1'b0, 32'h00000080);
    acc_a(1'b0, B, 1'b1, 32'h20, 32'h0);           rsp_a("lb20", 1'b0, 32'hFFFFFFF0);
    acc_a(1'b0, H, 1'b1, 32'h22, 32'h0);           rsp_a("lh22", 1'b0, 32'h0);
    acc_a(1'b0, W, 1'b1, 32'h20, 32'h0);           rsp_a("lw20s", 1'b0, 32'h000080F0);

    acc_a(1'b1, H, 1'b0, 32'h32, 32'hAAAABEEF);    rsp_a("sh32", 1'b0, 32'h0);
    acc_a(1'b0, W, 1'b0, 32'h30, 32'h0);           rsp_a("lw30", 1'b0, 32'hBEEF0000);

    acc_a(1'b1, W, 1'b0, 32'h13, 32'hFFFFFFFF);    rsp_a("sw13", 1'b1, 32'h0);
    chk("sw13.err_addr", err_addr, 32'h13);
    acc_a(1'b0, W, 1'b0, 32'h10, 32'h0);           rsp_a("lw10b", 1'b0, 32'h11AA3344);
    chk("hold.err_addr", err_addr, 32'h13);
    acc_a(1'b0, W, 1'b0, 32'h400, 32'h0);          rsp_a("lw400", 1'b1, 32'h0);
    chk("lw400.err_addr", err_addr, 32'h400);
    acc_a(1'b0, H, 1'b1, 32'h21, 32'h0);           rsp_a("lh21", 1'b1, 32'h0);
    acc_a(1'b0, X, 1'b0, 32'h24, 32'h0);           rsp_a("size11", 1'b1, 32'h0);
    chk("size11.err_addr", err_addr, 32'h24);

    // Asynchronous reset with a response on the outputs.
    acc_a(1'b0, W, 1'b0, 32'h10, 32'h0);
    chk("async.pre", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async.rsp_rdata", rsp_rdata, 32'h0);
    chk("async.err_addr",  err_addr, 32'h0);
    chk("async.req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 2000) begin step(); n++; end
    chk("reclear.len", 32'(n), 32'd256);
    acc_a(1'b0, W, 1'b0, 32'h10, 32'h0);           rsp_a("lw10c", 1'b0, 32'h0);

    // Instance b: latency 2, back-to-back store then load.
    chk("b.ready", 32'(req_ready_b), 32'd1);
    drive_b(1'b1, W, 32'h8, 32'hDEADBEEF);
    step();
    chk("b.sw.early", 32'(rsp_valid_b), 32'd0);
    drive_b(1'b0, W, 32'h8, 32'h0);
    step();
    req_valid_b = 1'b0;
    chk("b.sw.valid", 32'(rsp_valid_b), 32'd1);
    chk("b.sw.rdata", rsp_rdata_b, 32'h0);
    step();
    chk("b.lw.valid", 32'(rsp_valid_b), 32'd1);
    chk("b.lw.rdata", rsp_rdata_b, 32'hDEADBEEF);
    chk("b.lw.err",   32'(rsp_err_b), 32'd0);
    step();
    chk("b.idle", 32'(rsp_valid_b), 32'd0);

    drive_b(1'b0, W, 32'h40, 32'h0);
    step();
    req_valid_b = 1'b0;
    step();
    chk("b.oob.valid", 32'(rsp_valid_b), 32'd1);
    chk("b.oob.err",   32'(rsp_err_b), 32'd1);
    chk("b.oob.addr",  err_addr_b, 32'h40);

    // Reset one cycle after a load is accepted: that response must vanish.
    drive_b(1'b0, W, 32'h8, 32'h0);
    step();
    req_valid_b = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("b.drop0", 32'(rsp_valid_b), 32'd0);
    n = 0;
    while (!req_ready_b && n < 200) begin
      if (rsp_valid_b) chk("b.drop.pending", 32'(rsp_valid_b), 32'd0);
      step();
      n++;
    end
    chk("b.reclear.len", 32'(n), 32'd16);
    drive_b(1'b0, W, 32'h8, 32'h0);
    step();
    req_valid_b = 1'b0;
    step();
    chk("b.lw8.valid", 32'(rsp_valid_b), 32'd1);
    chk("b.lw8.rdata", rsp_rdata_b, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_subword.md
DATA_MEM_SUBWORD -- requirements
Module: data_mem_subword

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from request acceptance to response; legal values 1 or 2.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-sweep the array after reset.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block can accept a request.
REQ-008 SHALL have port req_write  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal.
REQ-010 SHALL have port req_signed  in  1  sign-extend sub-word loads.
REQ-011 SHALL have port req_addr  in  32  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  out  32  load data, extended to 32 bits.
REQ-015 SHALL have port rsp_err  out  1  access fault, qualified by rsp_valid.
REQ-016 SHALL have port err_addr  out  32  address of most recent faulting request.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL use little-endian lanes: byte n of a word is at bits 8n+7:8n; word index = addr[31:2].
REQ-019 SHALL commit a store at the acceptance edge, byte-enabled: byte writes lane addr[1:0], half writes lanes addr[1]*2 and addr[1]*2+1, word writes all four lanes.
REQ-020 SHALL produce exactly one response per accepted request, in order, READ_LATENCY cycles after acceptance, for loads and stores alike; store responses carry rsp_rdata=0.
REQ-021 SHALL zero-extend sub-word load data when req_signed=0, sign-extend it when 1; req_signed is ignored for word loads.
REQ-022 SHALL flag a fault (rsp_err=1, rsp_rdata=0, no array write) for: half access with addr[0]=1, word access with addr[1:0]!=0, req_size=11, or word index >= DEPTH.
REQ-023 SHALL load err_addr with req_addr at the acceptance edge of each faulting request, and hold it otherwise.
REQ-024 SHALL return, for a load accepted the cycle after a store to the same word, the post-store data (write-then-read ordering).
REQ-025 SHALL sustain one request per cycle in READY state at either latency (fully pipelined, READ_LATENCY-deep response shift register).
REQ-026 SHALL implement FSM states CLEAR and READY: after reset enter CLEAR if CLEAR_ON_RESET=1, else READY; CLEAR writes zero to one word per cycle from index 0 to DEPTH-1, then moves to READY on the cycle after index DEPTH-1 is written.
REQ-027 SHALL drive req_ready=0 in CLEAR and req_ready=1 in READY.

Reset
REQ-028 SHALL, while rst=1, force rsp_valid=0, rsp_rdata=0, rsp_err=0, err_addr=0, req_ready=0, clear counter=0, and discard all in-flight responses.
REQ-029 SHALL, on rst asserted mid-CLEAR or with responses pending, drop all pending responses and restart the sweep from index 0 (when CLEAR_ON_RESET=1).
REQ-030 SHALL not reset the storage array asynchronously; array contents are defined only by the CLEAR sweep or by stores.

Structure
REQ-031 SHALL place the req_size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state encoding in the shared processor package used by the load/store path.
REQ-032 SHALL factor lane steering and sign/zero extension into one combinational sub-module, mem_lane_align, reused by loads and stores.

Verification
REQ-033 SHALL cover: reset with CLEAR_ON_RESET=1, DEPTH=256 -> req_ready=0 for exactly 256 cycles, then 1; a word load of address 0x40 returns 0x00000000.
REQ-034 SHALL cover: word store 0x11223344 to 0x10, then byte store 0xAA to 0x12 -> word load of 0x10 returns 0x11AA3344.
REQ-035 SHALL cover: word 0x0000_80F0 at 0x20; signed half load of 0x20 -> 0xFFFF80F0; unsigned -> 0x000080F0; signed byte load of 0x21 -> 0xFFFFFF80.
REQ-036 SHALL cover: word store to 0x13 -> rsp_err=1, err_addr=0x13, word at 0x10 unchanged; load of address 0x400 at DEPTH=256 -> rsp_err=1.
REQ-037 SHALL cover: READ_LATENCY=2, back-to-back store 0xDEADBEEF to 0x8 then load 0x8 -> responses on consecutive cycles, second returns 0xDEADBEEF.
REQ-038 SHALL cover: rst pulsed one cycle after a load is accepted -> no rsp_valid for that load; CLEAR restarts from index 0.
